// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: recovers per-position character codes and dots from a multiplexed seven-segment bus
module seven_seg_scan_decoder #(
  parameter int w_digit       = 8,
  parameter int stable_cycles = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_abcdefgh,
  input  logic [w_digit-1:0]   i_digit,
  output logic [5*w_digit-1:0] o_frame_codes,
  output logic [w_digit-1:0]   o_frame_dots,
  output logic                 o_frame_valid,
  input  logic                 i_frame_ready,
  output logic                 o_unknown_seen,
  output logic                 o_overrun
);
  localparam int cw = $clog2(stable_cycles);
  localparam int iw = w_digit > 1 ? $clog2(w_digit) : 1;
  logic [7:0]         r_abcdefgh;
  logic [w_digit-1:0] r_digit;
  logic [cw-1:0]      r_cnt;
  logic [4:0]         r_slot [w_digit];
  logic [w_digit-1:0] r_slot_dot;
  logic [w_digit-1:0] r_seen;
  logic               w_onehot;
  logic               w_same;
  logic               w_capture;
  logic               w_complete;
  logic [cw-1:0]      w_cnt_next;
  logic [iw-1:0]      w_idx;
  logic [4:0]         w_code;
  logic [5*w_digit-1:0] w_codes;
  logic               w_unknown;
  assign w_onehot   = (i_digit != '0) && ((i_digit & (i_digit - w_digit'(1))) == '0);
  assign w_same     = {i_abcdefgh, i_digit} == {r_abcdefgh, r_digit};
  assign w_cnt_next = !(w_onehot && w_same) ? '0 :
                      (r_cnt == cw'(stable_cycles - 1)) ? r_cnt : r_cnt + cw'(1);
  // r_cnt saturates at stable_cycles-1, so a long run hits stable_cycles-2 only once
  assign w_capture  = w_onehot && w_same && (r_cnt == cw'(stable_cycles - 2));
  assign w_complete = &r_seen;
  always_comb begin
    w_idx     = '0;
    w_codes   = '0;
    w_unknown = 1'b0;
    for (int i = 0; i < w_digit; i++) begin
      w_idx              = i_digit[i] ? iw'(i) : w_idx;
      w_codes[5*i +: 5]  = r_slot[i];
      w_unknown          = w_unknown | (r_slot[i] == 5'd31);
    end
  end
  always_comb begin
    case (i_abcdefgh[7:1])
      7'b1111110: w_code = 5'd0;
      7'b0110000: w_code = 5'd1;
      7'b1101101: w_code = 5'd2;
      7'b1111001: w_code = 5'd3;
      7'b0110011: w_code = 5'd4;
      7'b1011011: w_code = 5'd5;
      7'b1011111: w_code = 5'd6;
      7'b1110000: w_code = 5'd7;
      7'b1111111: w_code = 5'd8;
      7'b1111011: w_code = 5'd9;
      7'b1110111: w_code = 5'd10;
      7'b0011111: w_code = 5'd11;
      7'b1001110: w_code = 5'd12;
      7'b0111101: w_code = 5'd13;
      7'b1001111: w_code = 5'd14;
      7'b1000111: w_code = 5'd15;
      7'b1100111: w_code = 5'd16;
      7'b1011110: w_code = 5'd17;
      7'b0111110: w_code = 5'd18;
      7'b0110111: w_code = 5'd19;
      7'b0000000: w_code = 5'd20;
      default:    w_code = 5'd31;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_abcdefgh     <= '0;
      r_digit        <= '0;
      r_cnt          <= '0;
      r_seen         <= '0;
      r_slot_dot     <= '0;
      for (int i = 0; i < w_digit; i++) r_slot[i] <= 5'd20;
      o_frame_codes  <= {w_digit{5'd20}};
      o_frame_dots   <= '0;
      o_frame_valid  <= 1'b0;
      o_unknown_seen <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_abcdefgh <= i_abcdefgh;
      r_digit    <= i_digit;
      r_cnt      <= w_cnt_next;
      if (w_capture) begin
        r_slot[w_idx]     <= w_code;
        r_slot_dot[w_idx] <= i_abcdefgh[0];
      end
      r_seen <= (w_complete ? '0 : r_seen) | (w_capture ? i_digit : '0);
      if (w_complete && (!o_frame_valid || i_frame_ready)) begin
        o_frame_codes  <= w_codes;
        o_frame_dots   <= r_slot_dot;
        o_unknown_seen <= w_unknown;
        o_frame_valid  <= 1'b1;
      end else if (i_frame_ready) begin
        o_frame_valid <= 1'b0;
      end
      if (w_complete && o_frame_valid && !i_frame_ready) o_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed scenarios for the seven-segment bus decoder
module tb_seven_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [19:0] frame_codes;
  logic [3:0]  frame_dots;
  logic        frame_valid;
  logic        frame_ready;
  logic        unknown_seen;
  logic        overrun;
  int checks = 0;
  int errors = 0;
  int vcount;
  logic [19:0] lc;
  logic [3:0]  ld;
  logic        lu;
  seven_seg_scan_decoder #(.w_digit(4), .stable_cycles(4)) dut (
    .clk(clk), .rst(rst), .i_abcdefgh(abcdefgh), .i_digit(digit),
    .o_frame_codes(frame_codes), .o_frame_dots(frame_dots), .o_frame_valid(frame_valid),
    .i_frame_ready(frame_ready), .o_unknown_seen(unknown_seen), .o_overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [3:0] d, input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      digit = d;
      abcdefgh = p;
      @(posedge clk);
      #1;
      if (frame_valid) begin
        vcount++;
        lc = frame_codes;
        ld = frame_dots;
        lu = unknown_seen;
      end
    end
  endtask
  task automatic show(input int pos, input logic [7:0] p, input int n);
    drive(4'b0001 << pos, p, n);
  endtask
  task automatic test_reset;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      abcdefgh = 8'($urandom);
      digit = 4'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    checks++; if (frame_codes !== {4{5'd20}}) begin errors++; $display("FAIL reset_codes got %h want %h", frame_codes, {4{5'd20}}); end
    checks++; if (frame_dots !== 4'b0) begin errors++; $display("FAIL reset_dots got %b want 0000", frame_dots); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    checks++; if (overrun !== 1'b0 || unknown_seen !== 1'b0) begin errors++; $display("FAIL reset_flags got ovr=%b unk=%b want 0 0", overrun, unknown_seen); end
  endtask
  task automatic test_frame;
    vcount = 0;
    frame_ready = 1'b1;
    show(3, 8'h8E, 6); show(2, 8'hCE, 6); show(1, 8'hBC, 6); show(0, 8'hEE, 6);
    drive(4'b0, 8'h00, 6);
    checks++; if (vcount !== 1) begin errors++; $display("FAIL frame_valid_cycles got %0d want 1", vcount); end
    checks++; if (lc !== {5'd15, 5'd16, 5'd17, 5'd10}) begin errors++; $display("FAIL frame_codes got %h want %h", lc, {5'd15, 5'd16, 5'd17, 5'd10}); end
    checks++; if (ld !== 4'b0 || lu !== 1'b0) begin errors++; $display("FAIL frame_dots_unk got %b %b want 0000 0", ld, lu); end
  endtask
  task automatic test_glitch;
    vcount = 0;
    show(0, 8'h3E, 3);
    drive(4'b0, 8'h00, 4);
    show(3, 8'h9C, 4); show(2, 8'h7A, 4); show(1, 8'h9E, 4);
    drive(4'b0, 8'h00, 8);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL glitch_no_frame got %0d valid cycles want 0", vcount); end
    show(0, 8'hF6, 4);
    drive(4'b0, 8'h00, 6);
    checks++; if (vcount !== 1) begin errors++; $display("FAIL glitch_frame_cycles got %0d want 1", vcount); end
    checks++; if (lc !== {5'd12, 5'd13, 5'd14, 5'd9}) begin errors++; $display("FAIL glitch_codes got %h want %h", lc, {5'd12, 5'd13, 5'd14, 5'd9}); end
  endtask
  task automatic test_invalid_select;
    vcount = 0;
    drive(4'b0110, 8'hFE, 20);
    show(3, 8'hB6, 6); show(0, 8'hBE, 6);
    drive(4'b0, 8'h00, 10);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL invalid_no_frame got %0d valid cycles want 0", vcount); end
    show(2, 8'h7C, 6); show(1, 8'h6E, 6);
    drive(4'b0, 8'h00, 4);
    checks++; if (vcount !== 1) begin errors++; $display("FAIL invalid_frame_cycles got %0d want 1", vcount); end
    checks++; if (lc !== {5'd5, 5'd18, 5'd19, 5'd6}) begin errors++; $display("FAIL invalid_codes got %h want %h", lc, {5'd5, 5'd18, 5'd19, 5'd6}); end
  endtask
  task automatic test_backpressure;
    frame_ready = 1'b0;
    show(3, 8'h60, 6); show(2, 8'hDA, 6); show(1, 8'hF2, 6); show(0, 8'h66, 6);
    drive(4'b0, 8'h00, 3);
    checks++; if (frame_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL bp_first got valid=%b ovr=%b want 1 0", frame_valid, overrun); end
    show(3, 8'hB6, 6); show(2, 8'hBE, 6); show(1, 8'hE0, 6); show(0, 8'hFE, 6);
    drive(4'b0, 8'h00, 3);
    checks++; if (frame_codes !== {5'd1, 5'd2, 5'd3, 5'd4}) begin errors++; $display("FAIL bp_hold_codes got %h want %h", frame_codes, {5'd1, 5'd2, 5'd3, 5'd4}); end
    checks++; if (frame_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got valid=%b ovr=%b want 1 1", frame_valid, overrun); end
    frame_ready = 1'b1;
    drive(4'b0, 8'h00, 1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got valid=%b want 0", frame_valid); end
    drive(4'b0, 8'h00, 4);
    checks++; if (frame_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL bp_after got valid=%b ovr=%b want 0 1", frame_valid, overrun); end
  endtask
  task automatic test_unknown_dot;
    vcount = 0;
    show(3, 8'hFC, 6); show(2, 8'h91, 6); show(1, 8'h61, 6); show(0, 8'h00, 6);
    drive(4'b0, 8'h00, 4);
    checks++; if (vcount !== 1) begin errors++; $display("FAIL unk_frame_cycles got %0d want 1", vcount); end
    checks++; if (lc !== {5'd0, 5'd31, 5'd1, 5'd20}) begin errors++; $display("FAIL unk_codes got %h want %h", lc, {5'd0, 5'd31, 5'd1, 5'd20}); end
    checks++; if (ld !== 4'b0110 || lu !== 1'b1) begin errors++; $display("FAIL unk_dots_flag got %b %b want 0110 1", ld, lu); end
  endtask
  task automatic test_mid_reset;
    vcount = 0;
    show(3, 8'hE0, 6); show(2, 8'hFE, 6);
    rst = 1'b0;
    drive(4'b0, 8'h00, 1);
    rst = 1'b1;
    checks++; if (frame_codes !== {4{5'd20}} || frame_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_state got codes=%h valid=%b ovr=%b want %h 0 0", frame_codes, frame_valid, overrun, {4{5'd20}}); end
    show(1, 8'hF6, 6); show(0, 8'hEE, 6);
    drive(4'b0, 8'h00, 10);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL midrst_no_frame got %0d valid cycles want 0", vcount); end
    show(3, 8'hE0, 6); show(2, 8'hFE, 6); show(1, 8'hF6, 6); show(0, 8'hEE, 6);
    drive(4'b0, 8'h00, 4);
    checks++; if (vcount !== 1 || lc !== {5'd7, 5'd8, 5'd9, 5'd10} || lu !== 1'b0) begin errors++; $display("FAIL midrst_frame got n=%0d codes=%h unk=%b want 1 %h 0", vcount, lc, lu, {5'd7, 5'd8, 5'd9, 5'd10}); end
  endtask
  initial begin
    rst = 1'b0;
    frame_ready = 1'b1;
    abcdefgh = 8'h00;
    digit = 4'b0;
    lc = '0;
    ld = '0;
    lu = 1'b0;
    vcount = 0;
    #1;
    test_reset;
    test_frame;
    test_glitch;
    test_invalid_select;
    test_backpressure;
    test_unknown_dot;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receiving end of the dynamic seven-segment bus: samples a multiplexed abcdefgh/digit pair (as driven to the board display) and recovers one character code plus dot per digit position.
- Assembles complete frames and hands them out over a valid/ready interface.
- Used for loopback self-checking of display drivers and for reading a display bus on GPIO.

Parameters:
- w_digit, 8, number of digit positions, one-hot select width.
- stable_cycles, 4, consecutive identical samples required before a digit is captured, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- abcdefgh  input  8  segment pattern; bit 7 = a … bit 1 = g, bit 0 = h (dot); 1 = lit.
- digit  input  w_digit  digit select, one-hot active-high; bit i = position i.
- frame_codes  output  5*w_digit  character code per position; position i at [5*i+4:5*i].
- frame_dots  output  w_digit  dot (h) per position.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts frame.
- unknown_seen  output  1  at least one position in the current output frame decoded to code 31.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (rst == 0 at a clk edge): all frame_codes = 20 (space), frame_dots = 0, frame_valid = 0, unknown_seen = 0, overrun = 0. Stability counter, capture slots and seen mask are cleared. The same clearing applies mid-frame; a partial frame is discarded.
- Decode of abcdefgh[7:1]:
  - Hex digits: 0=1111110→0, 1=0110000→1, 2=1101101→2, 3=1111001→3, 4=0110011→4, 5=1011011→5, 6=1011111→6, 7=1110000→7, 8=1111111→8, 9=1111011→9, A=1110111→10, b=0011111→11, C=1001110→12, d=0111101→13, E=1001111→14, F=1000111→15.
  - Letters: P=1100111→16, G=1011110→17, V=0111110→18, K=0110111→19.
  - Blank: 0000000→20 (space).
  - Any other pattern → 31 (unknown).
  - The dot is taken from abcdefgh[0], independent of the code.
- Input sampling: {abcdefgh, digit} is registered once (1 cycle). The stability counter compares the current sample with the previous one.
  - Equal: the counter increments and saturates.
  - Different: the counter resets to 0.
- Sample validity: if digit is not exactly one-hot (zero bits or more than one bit set), the sample is invalid. The counter is held at 0 and nothing is captured.
- Capture: when the counter reaches stable_cycles-1 (the sample has been identical for stable_cycles consecutive cycles), the decoded code and dot are written to slot[index of the one-hot bit], and seen[index] is set.
  - Capture happens exactly once per stable run; a longer run does not recapture.
  - A later run on the same position overwrites that slot.
- Frame completion: when seen becomes all-ones, the next cycle copies the slots to frame_codes/frame_dots, computes unknown_seen, sets frame_valid = 1 and clears seen.
  - The capture that completes the frame is included in that frame.
- Handshake: frame_valid and the frame outputs stay stable while frame_valid && !frame_ready. A transfer occurs on a cycle with frame_valid && frame_ready; frame_valid drops the next cycle unless a new frame loads in the same cycle.
- Simultaneous events:
  - Completion on a cycle with frame_valid && frame_ready: the new frame loads and frame_valid stays 1.
  - Completion while frame_valid && !frame_ready: the new frame is dropped, overrun is set (sticky until reset), seen is still cleared and the outputs are unchanged.
- Latency: the first stable cycle of the last missing position is cycle t; frame_valid is 1 at cycle t + stable_cycles + 1.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random bus → frame_codes all 20, frame_valid=0, overrun=0.
- Frame "F,P,G,A" on positions 3..0 (patterns 1000_1110, 1100_1110, 1011_1100, 1110_1110), w_digit=4, 6 cycles per digit, frame_ready=1 → one frame with codes {15,16,17,10}, dots 0, unknown_seen=0, frame_valid high for 1 cycle.
- Glitch filter: stable_cycles=4, show digit 0 for only 3 cycles, then digit=0000 → no capture, frame_valid stays 0; then 4 stable cycles per position → frame produced.
- Invalid select: digit=0b0110 held for 20 cycles with pattern 8 → no capture and seen unchanged.
- Backpressure: frame_ready=0, complete two frames ("1234", then "5678") → outputs keep {1,2,3,4}, overrun=1; raise frame_ready → one transfer, frame_valid=0 next cycle.
- Unknown/dot: pattern 1001_0001 on position 2 → code 31, dot 1, unknown_seen=1 in that frame; mid-frame reset after 2 of 4 positions → no frame emitted, next full scan emits normally.
